hc04_sweep_checker: RTL and testbench

//  Stimulus/response stage wrapped around the W_74HC04 hex inverter on the lab board.

---
 rtl/hc04_chk_pkg.sv | 22 ++
 rtl/hc04_sync2.sv | 25 ++
 rtl/hc04_sweep_checker.sv | 113 +++++++++++
 tb/tb_hc04_sweep_checker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hc04_chk_pkg.sv
// Shared types and helpers for the 74HC04 sweep checker.
// Holds FSM state encoding, settle minimum and saturating increment.
package hc04_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int SETTLE_MIN = 3;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/hc04_sync2.sv
// WIDTH-wide two-flop synchronizer for the inverter outputs.
// Both stages reset asynchronously to zero.
module hc04_sync2 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // two back-to-back capture stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hc04_sweep_checker.sv
// Exhaustive sweep of a hex inverter: drives A, checks Y == ~A.
// Optional HC04_STOP_ON_FAIL_EN halts on the first failing vector.
module hc04_sweep_checker
  import hc04_chk_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int SETTLE_CYC = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic [WIDTH-1:0] A_OUT,
  input  logic [WIDTH-1:0] Y_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [WIDTH:0]   ERR_CNT,
  output logic [WIDTH-1:0] FAIL_MASK
);

  localparam int EW = WIDTH + 1;
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [31:0] ERR_MAX = 32'((64'd1 << EW) - 64'd1);

  if (SETTLE_CYC < SETTLE_MIN) begin : g_bad_settle
    $error("SETTLE_CYC is below SETTLE_MIN");
  end

  state_t           state;
  logic [WIDTH-1:0] pat;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] y_sync;
  logic [WIDTH-1:0] mism;
  logic [WIDTH:0]   err_nxt;
  logic             hit;
  logic             last;

  hc04_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (Y_IN),
    .q     (y_sync)
  );

  assign mism    = y_sync ^ ~A_OUT;
  assign hit     = (mism != '0);
  assign err_nxt = EW'(sat_inc(32'(ERR_CNT), ERR_MAX));

`ifdef HC04_STOP_ON_FAIL_EN
  assign last = (&pat) | hit;
`else
  assign last = &pat;
`endif

  // sweep sequencer with registered status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      pat       <= '0;
      cnt       <= '0;
      A_OUT     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_MASK <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state     <= ST_DRIVE;
            pat       <= '0;
            ERR_CNT   <= '0;
            FAIL_MASK <= '0;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
          end
        end
        ST_DRIVE: begin
          A_OUT <= pat;
          cnt   <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SAMPLE: begin
          if (hit) begin
            ERR_CNT   <= err_nxt;
            FAIL_MASK <= FAIL_MASK | mism;
          end
          if (last) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= !hit && (ERR_CNT == '0);
          end else begin
            pat   <= pat + WIDTH'(1);
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc04_sweep_checker.sv
// Scoreboard bench for hc04_sweep_checker with a fault-injecting inverter.
// Expected sweep results come from a per-vector channel model.
module tb_hc04_sweep_checker;

  localparam int W   = 6;
  localparam int SC  = 4;
  localparam int NV  = 1 << W;
  localparam int VEC = SC + 2;
`ifdef HC04_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A_OUT;
  logic [W-1:0] Y_IN;
  logic         BUSY;
  logic         DONE;
  logic         PASS;
  logic [W:0]   ERR_CNT;
  logic [W-1:0] FAIL_MASK;

  logic [W-1:0] flip  = '0;
  logic [W-1:0] smask = '0;
  logic [W-1:0] sval  = '0;

  // board model: inverter with per-channel stuck-at or non-inverting faults
  assign Y_IN = ((~A_OUT ^ flip) & ~smask) | (sval & smask);

  hc04_sweep_checker #(.WIDTH(W), .SETTLE_CYC(SC)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .A_OUT     (A_OUT),
    .Y_IN      (Y_IN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS),
    .ERR_CNT   (ERR_CNT),
    .FAIL_MASK (FAIL_MASK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           err;
    logic [W-1:0] mask;
    logic         pass;
    logic [W-1:0] a;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_t = 0;
  logic pbusy = 1'b0;
  logic pdone = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // what channel b returns for input bit ab under the current fault setup
  function automatic logic chan(input int b, input logic ab);
    if (smask[b]) return sval[b];
    if (flip[b]) return ab;
    return !ab;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.err  = 0;
    e.mask = '0;
    e.a    = W'(NV - 1);
    e.cyc  = NV * VEC;
    for (int v = 0; v < NV; v++) begin
      logic [W-1:0] a;
      logic [W-1:0] m;
      a = W'(v);
      m = '0;
      for (int b = 0; b < W; b++) m[b] = (chan(b, a[b]) == a[b]);
      if (m != '0) begin
        if (e.err < (1 << (W + 1)) - 1) e.err++;
        e.mask |= m;
        if (STOP) begin
          e.a   = a;
          e.cyc = (v + 1) * VEC;
          break;
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // monitor: times each sweep and checks results when DONE rises
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (BUSY && !pbusy) busy_t = cyc;
      if (DONE && !pdone) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("err_cnt", 32'(ERR_CNT), 32'(e.err));
          check("fail_mask", 32'(FAIL_MASK), 32'(e.mask));
          check("pass", 32'(PASS), 32'(e.pass));
          check("a_last", 32'(A_OUT), 32'(e.a));
          check("sweep_cycles", 32'(cyc - busy_t), 32'(e.cyc));
        end
      end
      pbusy = BUSY;
      pdone = DONE;
    end
  end

  task automatic run(input bit coincident, input bit noise);
    exp_t e;
    e = model();
    sbq.push_back(e);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'd1);
    check("done_cleared", 32'(DONE), 32'd0);
    check("cnt_cleared", 32'(ERR_CNT) | 32'(FAIL_MASK), 32'd0);
    for (int n = 2; n <= e.cyc + 2; n++) begin
      @(negedge CLK);
      START = (coincident && n == e.cyc) ||
              (noise && n < e.cyc && ($urandom % 40) == 0);
    end
    START = 1'b0;
    if (coincident) begin
      check("coinc_done_held", 32'(DONE), 32'd1);
      check("coinc_not_busy", 32'(BUSY), 32'd0);
    end
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge CLK);
    if (sbq.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  task automatic abort_test();
    int k;
    flip  = '0;
    smask = '0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (k = 0; k < 1000 && A_OUT != 6'h15; k++) @(negedge CLK);
    check("reach_15", 32'(A_OUT), 32'h15);
    #2 RST_N = 1'b0;
    #1;
    check("abort_a", 32'(A_OUT), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_flags", 32'({DONE, PASS}), 32'd0);
    check("abort_cnt", 32'(ERR_CNT) | 32'(FAIL_MASK), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    k = 0;
    repeat (20) begin
      @(negedge CLK);
      if (BUSY || DONE) k++;
    end
    check("idle_after_abort", 32'(k), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_a", 32'(A_OUT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_pass", 32'(PASS), 32'd0);
    check("rst_err", 32'(ERR_CNT), 32'd0);
    check("rst_mask", 32'(FAIL_MASK), 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    flip = '0;    smask = '0;    sval = '0;
    run(1'b0, 1'b1);
    smask = 6'h08; sval = 6'h00;
    run(1'b0, 1'b1);
    smask = '0;   flip = 6'h20;
    run(1'b0, 1'b0);
    flip = '0;
    run(1'b1, 1'b0);
    smask = 6'h04; sval = 6'h04;
    run(1'b0, 1'b1);
    abort_test();
    repeat (6) begin
      flip  = W'($urandom & $urandom & $urandom);
      smask = W'($urandom & $urandom & $urandom);
      sval  = W'($urandom);
      run(1'b0, 1'b1);
    end
    flip = '0;    smask = '0;
    run(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
